im_boot_loader: RTL and testbench
=================================

Name: im_boot_loader

Overview:
- Sequences instruction-memory initialisation from a byte stream (UART receiver or test host) at power-up or on command.
- Assembles 32-bit words, drives the IMem write port (address, write data, write enable) and holds the CPU core in reset until the image is loaded and its checksum verified.
- Sits at top level beside the IMem. Top level muxes IMem PC between the loader address (load_active=1) and the core PC.

Parameters:
- IMEM_SIZE, 128, IMem depth in 32-bit words; maximum accepted word count.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading.
- AUTO_START, 1, if 1 a load begins automatically after reset; if 0 it waits for start.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a (re)load from IDLE, DONE or ERR
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready)
- im_addr  output  32  IMem byte address (word index << 2)
- im_wdata  output  32  assembled instruction word
- im_we  output  1  IMem write enable, one cycle per word
- load_active  output  1  PC-mux select; 1 = loader owns the IMem address
- cpu_rst  output  1  reset to CPU core, active-high
- done  output  1  image loaded and checksum good (level)
- err  output  1  load failed (level)
- err_code  output  2  0 none, 1 bad length, 2 timeout, 3 checksum mismatch

Behaviour:
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first, then one CHK byte equal to the XOR of all preceding data bytes (length bytes excluded).
- Reset values: state IDLE, byte_ready 0, im_addr 0, im_wdata 0, im_we 0, load_active 0, cpu_rst 1, done 0, err 0, err_code 0; all counters 0.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
- IDLE: if AUTO_START=1, go to LEN_HI in the first cycle after reset; otherwise wait for start. cpu_rst stays 1.
- On entry to LEN_HI: clear word index, byte index, checksum and timeout counter. Set load_active 1, done 0, err 0, err_code 0.
- LEN_HI, LEN_LO, DATA, CHK: byte_ready 1. Each transfer clears the timeout counter.
- After LEN_LO: if N==0 or N>IMEM_SIZE, go to ERR with code 1. Otherwise go to DATA.
- DATA: shift each byte into im_wdata (im_wdata <= {im_wdata[23:0], byte}) and XOR it into the checksum. The 4th byte goes to WRITE.
- WRITE: one cycle, byte_ready 0, im_we 1, im_addr = word_index<<2. Next cycle: word_index+1, im_addr updated, then back to DATA, or to CHK if word_index+1==N.
- Total: 4 transfer cycles plus 1 write cycle per word minimum.
- CHK: received byte == checksum goes to DONE; otherwise ERR with code 3.
- Timeout: in LEN_HI through CHK excluding WRITE, the counter increments each cycle without a transfer. Reaching TIMEOUT_CYCLES goes to ERR with code 2.
- DONE: load_active 0, cpu_rst 0, done 1, byte_ready 0. Incoming bytes are ignored.
- ERR: load_active 0, cpu_rst 1, err 1. The IMem may be partially written.
- start in DONE or ERR goes to LEN_HI and re-asserts cpu_rst the next cycle. start in any loading state is ignored.
- RST asserted mid-load: everything returns to reset values the next cycle. Any in-flight im_we is dropped, since im_we is registered and cleared by reset.
- im_we is never 1 while cpu_rst is 0.
- im_addr never exceeds (IMEM_SIZE-1)<<2.

Decomposition:
- Shared package holds the state encoding constants, err_code values and the frame field widths (LEN 16 bits, byte 8 bits).
- One natural sub-module, im_word_assembler: byte shift register, byte index, running XOR checksum, with clear/enable inputs and a word_ready output.
- The FSM, timeout counter and address generation stay in im_boot_loader.

Test Plan:
- Normal load, AUTO_START=1: stream 00 02, 20 08 00 05, 00 00 00 08, CHK=0x25 → im_we pulses at addr 0x0 (0x20080005) and 0x4 (0x00000008); done=1, cpu_rst=0 one cycle after the CHK transfer.
- Bad length: stream 00 81 with IMEM_SIZE=128 → err=1, err_code=1, no im_we; same result for 00 00.
- Checksum error: valid 1-word frame DE AD BE EF with CHK 0x00 (correct is 0x22) → one im_we, then err_code=3, cpu_rst stays 1.
- Timeout: TIMEOUT_CYCLES=16, stop after 2 data bytes → err_code=2 exactly 16 cycles after the last transfer.
- Back-pressure and gaps: random byte_valid gaps shorter than the timeout, byte_valid held high during WRITE → no byte lost or duplicated; memory contents match the image.
- RST mid-load after 5 words, then start with AUTO_START=0 → all outputs at reset values; the reload rewrites from addr 0 and ends with done=1.

Source files
------------

// File: rtl/im_boot_loader_pkg.sv
// im_boot_loader_pkg: shared frame widths, FSM states and error codes for the IMem boot loader
// Ports: none (package).
package im_boot_loader_pkg;
   localparam int LEN_W  = 16;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_e;
   typedef enum logic [1:0] {
      E_NONE = 2'd0,
      E_LEN  = 2'd1,
      E_TMO  = 2'd2,
      E_CHK  = 2'd3
   } err_e;
endpackage

// File: rtl/im_boot_loader_word.sv
// im_word_assembler: packs stream bytes MSB-first into 32-bit words and keeps a running XOR checksum
// Ports: CLK/RST clock and sync active-high reset; clr clears byte index and checksum;
//   en accepts byte_in; word assembled word; chk running XOR; word_ready high on the 4th byte.
module im_word_assembler
   import im_boot_loader_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic [BYTE_W-1:0] chk,
   output logic              word_ready
);
   logic [WORD_W-1:0] word_q, word_d;
   logic [BYTE_W-1:0] chk_q, chk_d;
   logic [1:0]        idx_q, idx_d;
   always_comb begin
      word_d = en ? {word_q[WORD_W-BYTE_W-1:0], byte_in} : word_q;
      chk_d  = clr ? '0 : en ? chk_q ^ byte_in : chk_q;
      idx_d  = clr ? '0 : en ? idx_q + 2'd1 : idx_q;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         word_q <= '0;
         chk_q  <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         chk_q  <= chk_d;
         idx_q  <= idx_d;
      end
   end
   assign word       = word_q;
   assign chk        = chk_q;
   assign word_ready = en & (idx_q == 2'd3);
endmodule

// File: rtl/im_boot_loader.sv
// im_boot_loader: loads the instruction memory from a length-prefixed, XOR-checked byte stream
// Ports: CLK/RST clock and sync active-high reset; start (re)load pulse;
//   byte_valid/byte_data/byte_ready stream handshake; im_addr/im_wdata/im_we IMem write port;
//   load_active PC-mux select; cpu_rst core reset; done/err/err_code load status.
module im_boot_loader
   import im_boot_loader_pkg::*;
#(
   parameter int IMEM_SIZE      = 128,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter bit AUTO_START     = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              byte_ready,
   output logic [WORD_W-1:0] im_addr,
   output logic [WORD_W-1:0] im_wdata,
   output logic              im_we,
   output logic              load_active,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_e            state_q, state_d;
   err_e              code_q, code_d;
   logic [LEN_W-1:0]  len_q, len_d, widx_q, widx_d, len_n;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [BYTE_W-1:0] chk;
   logic              xfer, enter, len_bad, last_word, tmo_hit, asm_en, word_ready;
   assign xfer      = byte_valid & byte_ready;
   assign len_n     = {len_q[LEN_W-1:BYTE_W], byte_data};
   assign len_bad   = (len_n == '0) || (32'(len_n) > IMEM_SIZE);
   assign last_word = (widx_q + LEN_W'(1)) == len_q;
   assign tmo_hit   = byte_ready & ~byte_valid & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign enter     = (state_d == S_LEN_HI) & (state_q != S_LEN_HI);
   assign asm_en    = (state_q == S_DATA) & xfer;
   im_word_assembler u_asm (
      .CLK        (CLK),
      .RST        (RST),
      .clr        (enter),
      .en         (asm_en),
      .byte_in    (byte_data),
      .word       (im_wdata),
      .chk        (chk),
      .word_ready (word_ready)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         code_q  <= E_NONE;
         len_q   <= '0;
         widx_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         tmo_q   <= tmo_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:          if (AUTO_START || start) state_d = S_LEN_HI;
         S_LEN_HI:        if (xfer) state_d = S_LEN_LO;
         S_LEN_LO:        if (xfer) state_d = len_bad ? S_ERR : S_DATA;
         S_DATA:          if (word_ready) state_d = S_WRITE;
         S_WRITE:         state_d = last_word ? S_CHK : S_DATA;
         S_CHK:           if (xfer) state_d = (byte_data == chk) ? S_DONE : S_ERR;
         S_DONE, S_ERR:   if (start) state_d = S_LEN_HI;
         default:         state_d = S_IDLE;
      endcase
      if (tmo_hit) state_d = S_ERR;
   end
   // The word index stays on the last word so im_addr never points past the IMem.
   always_comb begin
      len_d  = (state_q == S_LEN_HI && xfer) ? {byte_data, len_q[BYTE_W-1:0]} :
               (state_q == S_LEN_LO && xfer) ? len_n : len_q;
      widx_d = enter ? '0 : (state_q == S_WRITE && !last_word) ? widx_q + LEN_W'(1) : widx_q;
      tmo_d  = (enter || xfer) ? '0 : byte_ready ? tmo_q + TW'(1) : tmo_q;
      code_d = enter ? E_NONE :
               (state_d == S_ERR && state_q != S_ERR) ?
                  (tmo_hit ? E_TMO : (state_q == S_LEN_LO) ? E_LEN : E_CHK) : code_q;
   end
   always_comb begin
      byte_ready  = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
      im_we       = state_q == S_WRITE;
      load_active = byte_ready | im_we;
      cpu_rst     = state_q != S_DONE;
      done        = state_q == S_DONE;
      err         = state_q == S_ERR;
      err_code    = code_q;
      im_addr     = {{(WORD_W-LEN_W-2){1'b0}}, widx_q, 2'b00};
   end
endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: randomized self-checking bench for im_boot_loader against a frame-level model
module tb_im_boot_loader;
   logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, im_we, load_active, cpu_rst, done, err;
   logic [31:0] im_addr, im_wdata;
   logic [1:0]  err_code;
   logic        m_byte_ready, m_im_we, m_load_active, m_cpu_rst, m_done, m_err;
   logic [31:0] m_im_addr, m_im_wdata;
   logic [1:0]  m_err_code;
   int          n_tests = 0, n_fail = 0;
   logic [7:0]  fq[$];
   logic [31:0] wa[$], wd[$];
   im_boot_loader #(.IMEM_SIZE(128), .TIMEOUT_CYCLES(16), .AUTO_START(1'b1)) dut (
      .CLK(CLK), .RST(RST), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
      .load_active(load_active), .cpu_rst(cpu_rst), .done(done), .err(err), .err_code(err_code)
   );
   im_boot_loader #(.IMEM_SIZE(128), .TIMEOUT_CYCLES(16), .AUTO_START(1'b0)) dut_m (
      .CLK(CLK), .RST(RST), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(m_byte_ready), .im_addr(m_im_addr), .im_wdata(m_im_wdata), .im_we(m_im_we),
      .load_active(m_load_active), .cpu_rst(m_cpu_rst), .done(m_done), .err(m_err),
      .err_code(m_err_code)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge CLK) begin
      if (im_we) begin
         wa.push_back(im_addr);
         wd.push_back(im_wdata);
         check("we_with_cpu_rst", 32'(cpu_rst), 32'd1);
         check("addr_in_range", 32'(im_addr <= 32'h1FC), 32'd1);
      end
   end
   task automatic check_reset(input string tag);
      check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_im_addr"}, im_addr, 32'd0);
      check({tag, "_im_wdata"}, im_wdata, 32'd0);
      check({tag, "_im_we"}, 32'(im_we), 32'd0);
      check({tag, "_load_active"}, 32'(load_active), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_err_code"}, 32'(err_code), 32'd0);
   endtask
   task automatic send_byte(input logic [7:0] b, input int gmax);
      int g, w;
      g = $urandom_range(gmax, 0);
      w = 0;
      if (g > 0) begin
         byte_valid = 1'b0;
         repeat (g) @(negedge CLK);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && w < 50) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 50) check("byte_ready_wait", 32'(byte_ready), 32'd1);
      @(negedge CLK);
   endtask
   task automatic do_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("start_load_active", 32'(load_active), 32'd1);
      check("start_cpu_rst", 32'(cpu_rst), 32'd1);
      check("start_done", 32'(done), 32'd0);
      check("start_err", 32'(err), 32'd0);
   endtask
   task automatic build(input int n, input bit bad);
      logic [7:0] x, b;
      x = '0;
      fq.delete();
      fq.push_back(8'(n >> 8));
      fq.push_back(8'(n));
      if (n == 0 || n > 128) return;
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         fq.push_back(b);
         x ^= b;
      end
      fq.push_back(bad ? x ^ 8'($urandom_range(255, 1)) : x);
   endtask
   // Reference: parse the frame by its rules and predict status and every IMem write.
   task automatic run_frame(input string tag, input int gmax);
      int n, code, nw;
      logic [7:0]  x;
      logic [31:0] w;
      wa.delete();
      wd.delete();
      foreach (fq[i]) send_byte(fq[i], gmax);
      byte_valid = 1'b0;
      n    = int'({fq[0], fq[1]});
      code = (n == 0 || n > 128) ? 1 : 0;
      nw   = (code != 0) ? 0 : n;
      x    = '0;
      for (int i = 0; i < 4 * nw; i++) x ^= fq[2 + i];
      if (code == 0 && fq[2 + 4 * nw] != x) code = 3;
      check({tag, "_done"}, 32'(done), 32'(code == 0));
      check({tag, "_err"}, 32'(err), 32'(code != 0));
      check({tag, "_err_code"}, 32'(err_code), 32'(code));
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(code != 0));
      check({tag, "_load_active"}, 32'(load_active), 32'd0);
      check({tag, "_writes"}, 32'(wa.size()), 32'(nw));
      for (int i = 0; i < nw && i < wa.size(); i++) begin
         w = {fq[2 + 4 * i], fq[3 + 4 * i], fq[4 + 4 * i], fq[5 + 4 * i]};
         check({tag, "_addr"}, wa[i], 32'(4 * i));
         check({tag, "_data"}, wd[i], w);
      end
   endtask
   initial begin
      int k;
      repeat (3) @(negedge CLK);
      check_reset("reset");
      RST = 1'b0;
      @(negedge CLK);
      check("auto_load_active", 32'(load_active), 32'd1);
      check("auto_byte_ready", 32'(byte_ready), 32'd1);
      check("manual_idle", 32'(m_load_active), 32'd0);
      fq = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
      run_frame("normal", 0);
      do_start();
      fq = {8'h00, 8'h81};
      run_frame("len129", 2);
      do_start();
      fq = {8'h00, 8'h00};
      run_frame("len0", 2);
      do_start();
      fq = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
      run_frame("bad_chk", 1);
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      byte_valid = 1'b0;
      k = 0;
      while (!err && k < 40) begin
         @(negedge CLK);
         k++;
      end
      check("tmo_cycles", 32'(k), 32'd16);
      check("tmo_code", 32'(err_code), 32'd2);
      check("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
      for (int t = 0; t < 8; t++) begin
         do_start();
         build((t == 0) ? 128 : (t == 1) ? 129 : $urandom_range(12, 1), $urandom_range(2, 0) == 0);
         run_frame("rand", 6);
      end
      do_start();
      build(8, 1'b0);
      for (int i = 0; i < 22; i++) send_byte(fq[i], 2);
      check("mid_im_we", 32'(im_we), 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      check_reset("rst_mid");
      check("rst_mid_m_load_active", 32'(m_load_active), 32'd0);
      byte_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("post_rst_auto", 32'(load_active), 32'd1);
      check("post_rst_manual_idle", 32'(m_load_active), 32'd0);
      check("post_rst_manual_cpu_rst", 32'(m_cpu_rst), 32'd1);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("manual_started", 32'(m_load_active), 32'd1);
      build(8, 1'b0);
      run_frame("reload", 4);
      check("reload_manual_done", 32'(m_done), 32'd1);
      check("reload_manual_err", 32'(m_err), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
